// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier-side signals of the shared multiplier scheduler.
// The arbiter connects through the slave modport. The requesters and the multiplier model connect through the master modport.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] op_a;
  logic [NUM_REQ*WIDTH-1:0] op_b;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [2*WIDTH-1:0]       result;
  logic [IDW-1:0]           result_id;
  logic                     err;
  logic                     busy;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_a;
  logic [WIDTH-1:0]         mult_b;
  logic                     mult_ready;
  logic [2*WIDTH-1:0]       mult_product;

  modport master (
    output req, op_a, op_b, mult_ready, mult_product,
    input  gnt, done, result, result_id, err, busy, mult_start, mult_a, mult_b
  );

  modport slave (
    input  req, op_a, op_b, mult_ready, mult_product,
    output gnt, done, result, result_id, err, busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler that shares one sequential multiplier between NUM_REQ requesters.
// A watchdog aborts an operation that never sees a ready edge.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 reset,
  mult_share_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t             state_reg;
  logic [IDW-1:0]     owner_reg;
  logic [IDW-1:0]     last_reg;
  logic [CW-1:0]      cnt_reg;
  logic               ready_q_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic [IDW-1:0]     result_id_reg;
  logic               err_reg;
  logic               busy_reg;
  logic               mult_start_reg;
  logic [WIDTH-1:0]   mult_a_reg;
  logic [WIDTH-1:0]   mult_b_reg;

  logic [WIDTH-1:0]   a_slice [NUM_REQ];
  logic [WIDTH-1:0]   b_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_slice[gi] = bus.op_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = bus.op_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Returns {found, index}. The search begins at last+1 and wraps, so the
  // requester served most recently has the lowest priority.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDW-1:0]     l);
    logic [IDW:0] res;
    int           cand;
    res = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(l) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (r[cand]) res = {1'b1, IDW'(cand)};
    end
    return res;
  endfunction

  logic [IDW:0]   pick;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           ready_evt;

  assign pick      = rr_pick(bus.req, last_reg);
  assign win_found = pick[IDW];
  assign win_idx   = pick[IDW-1:0];
  assign ready_evt = bus.mult_ready & ~ready_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_reg       <= IDW'(NUM_REQ - 1);
      cnt_reg        <= '0;
      ready_q_reg    <= 1'b0;
      gnt_reg        <= '0;
      done_reg       <= '0;
      result_reg     <= '0;
      result_id_reg  <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      mult_start_reg <= 1'b0;
      mult_a_reg     <= '0;
      mult_b_reg     <= '0;
    end else begin
      ready_q_reg    <= bus.mult_ready;
      gnt_reg        <= '0;
      done_reg       <= '0;
      mult_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            mult_a_reg     <= a_slice[win_idx];
            mult_b_reg     <= b_slice[win_idx];
            owner_reg      <= win_idx;
            gnt_reg        <= NUM_REQ'(1) << win_idx;
            mult_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A ready edge takes priority over the watchdog in the final cycle.
          if (ready_evt) begin
            result_reg    <= bus.mult_product;
            result_id_reg <= owner_reg;
            err_reg       <= 1'b0;
            done_reg      <= NUM_REQ'(1) << owner_reg;
            state_reg     <= DELIVER;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            result_reg    <= '0;
            result_id_reg <= owner_reg;
            err_reg       <= 1'b1;
            done_reg      <= NUM_REQ'(1) << owner_reg;
            state_reg     <= DELIVER;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DELIVER: begin
          last_reg  <= owner_reg;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.done       = done_reg;
  assign bus.result     = result_reg;
  assign bus.result_id  = result_id_reg;
  assign bus.err        = err_reg;
  assign bus.busy       = busy_reg;
  assign bus.mult_start = mult_start_reg;
  assign bus.mult_a     = mult_a_reg;
  assign bus.mult_b     = mult_b_reg;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: one task per scenario, hand-computed expectations.
// The bench also models the multiplier: it multiplies mult_a by mult_b when the bench asserts mult_ready.
module tb_mult_share_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mult_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

  mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.op_a[idx*W +: W] = a;
    bus.op_b[idx*W +: W] = b;
  endtask

  // Waits for a grant, then for done. Raises mult_ready rd cycles after the grant.
  // A negative rd value never raises ready. n counts the cycles from the grant to done.
  task automatic run_op(input int rd, input logic drop_req,
                        output logic [3:0] g, output logic [3:0] d,
                        output logic [15:0] r, output logic e,
                        output logic [1:0] id, output int n);
    int k;
    g = '0; d = '0; r = '0; e = 1'b0; id = '0; n = 0;
    k = 0;
    while (k < 20 && g == 4'b0) begin
      @(negedge clk);
      k++;
      g = bus.gnt;
    end
    if (g == 4'b0) return;
    if (drop_req) bus.req = '0;
    while (n < 200 && d == 4'b0) begin
      @(negedge clk);
      n++;
      if (bus.done != 4'b0) begin
        d  = bus.done;
        r  = bus.result;
        e  = bus.err;
        id = bus.result_id;
      end else if (n == rd) begin
        bus.mult_ready   = 1'b1;
        bus.mult_product = 16'(bus.mult_a) * 16'(bus.mult_b);
      end else begin
        bus.mult_ready = 1'b0;
      end
    end
    bus.mult_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req = '0; bus.op_a = '0; bus.op_b = '0;
    bus.mult_ready = 1'b0; bus.mult_product = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.done !== 4'b0) begin errors++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
    checks++; if (bus.result !== 16'd0) begin errors++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
    checks++; if (bus.result_id !== 2'd0) begin errors++; $display("FAIL reset_result_id got=%0d exp=0", bus.result_id); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mult_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", bus.mult_start); end
    checks++; if ({bus.mult_a, bus.mult_b} !== 16'd0) begin errors++; $display("FAIL reset_mult_ab got=%h exp=0000", {bus.mult_a, bus.mult_b}); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    logic [3:0] d; logic [15:0] r; logic e; logic [1:0] id; int n;
    set_ops(0, 8'd99, 8'd98); set_ops(1, 8'd13, 8'd11);
    set_ops(2, 8'd97, 8'd96); set_ops(3, 8'd95, 8'd94);
    bus.req = 4'b0010;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", bus.gnt); end
    checks++; if (bus.mult_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", bus.mult_start); end
    checks++; if (bus.mult_a !== 8'd13 || bus.mult_b !== 8'd11) begin errors++; $display("FAIL single_ops got=%0d,%0d exp=13,11", bus.mult_a, bus.mult_b); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_issue got=%b exp=1", bus.busy); end
    bus.req = '0;
    n = 0; d = '0;
    while (n < 40 && d == 4'b0) begin
      @(negedge clk);
      n++;
      if (bus.done != 4'b0) begin
        d = bus.done; r = bus.result; e = bus.err; id = bus.result_id;
      end else if (n == 10) begin
        bus.mult_ready = 1'b1;
        bus.mult_product = 16'(bus.mult_a) * 16'(bus.mult_b);
      end else begin
        bus.mult_ready = 1'b0;
      end
      if (n == 1 && (bus.gnt !== 4'b0 || bus.mult_start !== 1'b0)) begin
        checks++; errors++; $display("FAIL single_pulse_width gnt=%b start=%b exp=0000,0", bus.gnt, bus.mult_start);
      end
    end
    bus.mult_ready = 1'b0;
    checks++; if (n !== 11) begin errors++; $display("FAIL single_latency got=%0d exp=11", n); end
    checks++; if (d !== 4'b0010) begin errors++; $display("FAIL single_done got=%b exp=0010", d); end
    checks++; if (r !== 16'd143) begin errors++; $display("FAIL single_result got=%0d exp=143", r); end
    checks++; if (id !== 2'd1 || e !== 1'b0) begin errors++; $display("FAIL single_id_err got=%0d,%b exp=1,0", id, e); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_deliver got=%b exp=1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle got done=%b busy=%b exp=0000,0", bus.done, bus.busy); end
    checks++; if (bus.result !== 16'd143) begin errors++; $display("FAIL single_result_hold got=%0d exp=143", bus.result); end
    $display("test_single done");
  endtask

  task automatic test_round_robin;
    logic [3:0] g, d; logic [15:0] r; logic e; logic [1:0] id; int n;
    logic [3:0]  exp_g [5];
    logic [15:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{16'd2, 16'd12, 16'd28, 16'd50, 16'd2};
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    set_ops(0, 8'd2, 8'd1); set_ops(1, 8'd3, 8'd4);
    set_ops(2, 8'd4, 8'd7); set_ops(3, 8'd5, 8'd10);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_op(2, 1'b0, g, d, r, e, id, n);
      checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, g, exp_g[i]); end
      checks++; if (d !== exp_g[i] || r !== exp_r[i]) begin errors++; $display("FAIL rr_done[%0d] got=%b/%0d exp=%b/%0d", i, d, r, exp_g[i], exp_r[i]); end
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    $display("test_round_robin done");
  endtask

  task automatic test_max_operands;
    logic [3:0] g, d; logic [15:0] r; logic e; logic [1:0] id; int n;
    set_ops(2, 8'hFF, 8'hFF);
    bus.req = 4'b0100;
    run_op(4, 1'b1, g, d, r, e, id, n);
    checks++; if (d !== 4'b0100 || r !== 16'hFE01) begin errors++; $display("FAIL max_result got=%b/%h exp=0100/fe01", d, r); end
    checks++; if (id !== 2'd2 || e !== 1'b0) begin errors++; $display("FAIL max_id_err got=%0d,%b exp=2,0", id, e); end
    repeat (2) @(negedge clk);
    $display("test_max_operands done");
  endtask

  task automatic test_stale_ready;
    int early;
    int k;
    logic [3:0] d;
    set_ops(1, 8'd7, 8'd9);
    bus.mult_ready = 1'b1;
    bus.mult_product = 16'hDEAD;
    bus.req = 4'b0010;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL stale_gnt got=%b exp=0010", bus.gnt); end
    bus.req = '0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done != 4'b0) early++;
      if (i == 2) bus.mult_ready = 1'b0;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL stale_early_done got=%0d pulses exp=0", early); end
    bus.mult_ready = 1'b1;
    bus.mult_product = 16'd63;
    k = 0; d = '0;
    while (k < 10 && d == 4'b0) begin
      @(negedge clk);
      k++;
      d = bus.done;
    end
    bus.mult_ready = 1'b0;
    checks++; if (k !== 1 || d !== 4'b0010) begin errors++; $display("FAIL stale_done got=%b after %0d exp=0010 after 1", d, k); end
    checks++; if (bus.result !== 16'd63 || bus.err !== 1'b0) begin errors++; $display("FAIL stale_result got=%0d,%b exp=63,0", bus.result, bus.err); end
    repeat (2) @(negedge clk);
    $display("test_stale_ready done");
  endtask

  task automatic test_timeout;
    logic [3:0] g, d; logic [15:0] r; logic e; logic [1:0] id; int n;
    set_ops(0, 8'd5, 8'd6);
    bus.req = 4'b0001;
    run_op(-1, 1'b1, g, d, r, e, id, n);
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO + 1); end
    checks++; if (d !== 4'b0001 || e !== 1'b1) begin errors++; $display("FAIL timeout_done got=%b,%b exp=0001,1", d, e); end
    checks++; if (r !== 16'd0 || id !== 2'd0) begin errors++; $display("FAIL timeout_result got=%0d,%0d exp=0,0", r, id); end
    repeat (2) @(negedge clk);
    set_ops(0, 8'd200, 8'd3);
    bus.req = 4'b0001;
    run_op(3, 1'b1, g, d, r, e, id, n);
    checks++; if (d !== 4'b0001 || e !== 1'b0 || r !== 16'd600) begin errors++; $display("FAIL timeout_recover got=%b,%b,%0d exp=0001,0,600", d, e, r); end
    repeat (2) @(negedge clk);
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_wait;
    logic [3:0] g, d; logic [15:0] r; logic e; logic [1:0] id; int n;
    int stray;
    set_ops(1, 8'd12, 8'd12);
    bus.req = 4'b0010;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rstw_gnt got=%b exp=0010", bus.gnt); end
    bus.req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 4'b0 || bus.gnt !== 4'b0) begin errors++; $display("FAIL rstw_ctrl got busy=%b done=%b gnt=%b exp=0", bus.busy, bus.done, bus.gnt); end
    checks++; if (bus.result !== 16'd0 || bus.err !== 1'b0 || bus.result_id !== 2'd0) begin errors++; $display("FAIL rstw_result got=%0d,%b,%0d exp=0,0,0", bus.result, bus.err, bus.result_id); end
    checks++; if (bus.mult_a !== 8'd0 || bus.mult_b !== 8'd0) begin errors++; $display("FAIL rstw_mult_ab got=%0d,%0d exp=0,0", bus.mult_a, bus.mult_b); end
    bus.mult_ready = 1'b1;
    bus.mult_product = 16'd144;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done != 4'b0) stray++;
    end
    bus.mult_ready = 1'b0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstw_no_done got=%0d pulses exp=0", stray); end
    set_ops(3, 8'd21, 8'd4);
    bus.req = 4'b1000;
    run_op(2, 1'b1, g, d, r, e, id, n);
    checks++; if (g !== 4'b1000 || d !== 4'b1000 || r !== 16'd84) begin errors++; $display("FAIL rstw_after got=%b,%b,%0d exp=1000,1000,84", g, d, r); end
    repeat (2) @(negedge clk);
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_stale_ready();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
